vector_exec_unit: RTL and testbench
===================================

// Module: vector_exec_unit
// PURPOSE
//   Execute stage directly downstream of the operand picker. Captures functype/op1/op2 on start, runs
//   vector ops (VADD, VDOT, SMUL) over LANES_PER_CYCLE lanes per cycle, and completes scalar ops
//   (VLD/VST address, SLL/SLH) in one cycle. Drives a 256-bit result plus busy/done to writeback/memory.
// PARAMETERS
//   LANES            16  number of vector lanes
//   LANE_W           16  lane width, bits (LANES*LANE_W = 256)
//   LANES_PER_CYCLE   4  lanes processed per RUN cycle; must divide LANES; K = LANES/LANES_PER_CYCLE
// PORTS
//   clk       in   1    single clock, rising edge
//   rst_n     in   1    asynchronous active-low reset
//   start     in   1    request; accepted only when busy==0
//   functype  in   4    opcode from operand picker (VADD 0000, VDOT 0001, SMUL 0010, SST 0011,
//                       VLD 0100, VST 0101, SLL 0110, SLH 0111, NOP 1111)
//   op1       in   256  operand 1 (vector, or scalar in [15:0])
//   op2       in   256  operand 2 (vector; SMUL scalar / offset / immediate in low bits)
//   busy      out  1    high while in RUN
//   done      out  1    one-cycle pulse; result valid from this cycle until next accepted start
//   result    out  256  result; scalar results in [15:0], upper bits zero
// BEHAVIOUR
//   Reset: state=IDLE, busy=0, done=0, result=0, lane index=0, accumulator=0. Async assert at any
//     time (incl. mid-RUN) aborts the op; no done is produced for it.
//   FSM IDLE/RUN/DONE. start is accepted in IDLE or DONE (busy==0); ignored in RUN.
//     functype/op1/op2 registered on acceptance; upstream may change afterwards.
//   Vector ops: accept at edge N -> RUN cycles N+1..N+K (busy=1) -> DONE at N+K+1 (done=1, busy=0)
//     -> IDLE next cycle unless a new start is accepted. Default K=4: done at N+5.
//   Scalar/other ops: accept at edge N -> DONE at N+1 (latency 1), no RUN.
//   Lane chunk c (0..K-1) processes lanes c*LPC..c*LPC+LPC-1 in cycle N+1+c.
//   VADD: result[i] = op1[i] + op2[i], mod 2^16.
//   SMUL: result[i] = low 16 bits of signed op1[i] * op2[15:0].
//   VDOT: acc cleared on accept; acc += sum of chunk products (signed, low 16 bits); result={240'd0,acc}.
//   VLD/VST: result = {240'd0, op1[15:0] + op2[15:0]} (effective address, wraps).
//   SLL: result[15:0] = {op1[15:8], op2[7:0]}; SLH: result[15:0] = {op2[7:0], op1[7:0]}.
//   SST, NOP, undefined: result = 0, done still pulses after 1 cycle.
//   result is written only at transition into DONE; it holds during RUN (previous value) and after DONE.
//   start in the DONE cycle: accepted; done falls next cycle, next op proceeds normally (back-to-back).
// CONFIGURATION
//   SAT_ARITH_EN defined: VADD lane sums, SMUL lane products and every VDOT accumulate step saturate
//     to signed [-32768, 32767]. VLD/VST address add still wraps.
//   SAT_ARITH_EN undefined: all arithmetic wraps mod 2^16 as above.
// STRUCTURE
//   Package cvp14_pkg: functype localparams (shared with operand picker), exec FSM state enum,
//     LANES/LANE_W constants, sat16() helper function.
//   Sub-module vec_lane_alu: one 16-bit lane (add, signed multiply, optional saturation); instantiated
//     LANES_PER_CYCLE times with a lane-select mux driven by the chunk counter.
// TESTING
//   VADD op1 lanes=1..16, op2 lanes=0x0010 -> done at N+5, lane i = i+1+16, busy high 4 cycles.
//   VDOT op1 all 0x0002, op2 all 0x0003 -> result[15:0]=0x0060, result[255:16]=0.
//   VADD lane0 0x7FFF+0x0001 -> 0x8000 without SAT_ARITH_EN; 0x7FFF with it.
//   VLD op1=0x1000, op2=0xFFFE (offset -2) -> done at N+1, result[15:0]=0x0FFE.
//   start pulsed during RUN ignored; start in DONE cycle of VADD launches SLL op1=0xAB00, op2=0x34
//     -> result 0xAB34 one cycle later.
//   rst_n low in 2nd RUN cycle of SMUL -> busy/done/result 0 immediately; no done after release.

Source files
------------

// File: rtl/cvp14_pkg.sv
// Shared definitions for the CVP14 datapath: opcodes, exec FSM states, lane geometry
// and the signed 16-bit saturation helper.
package cvp14_pkg;

  localparam int LANES           = 16;
  localparam int LANE_W          = 16;
  localparam int LANES_PER_CYCLE = 4;
  localparam int VEC_W           = LANES * LANE_W;

  localparam logic [3:0] FT_VADD = 4'b0000;
  localparam logic [3:0] FT_VDOT = 4'b0001;
  localparam logic [3:0] FT_SMUL = 4'b0010;
  localparam logic [3:0] FT_SST  = 4'b0011;
  localparam logic [3:0] FT_VLD  = 4'b0100;
  localparam logic [3:0] FT_VST  = 4'b0101;
  localparam logic [3:0] FT_SLL  = 4'b0110;
  localparam logic [3:0] FT_SLH  = 4'b0111;
  localparam logic [3:0] FT_NOP  = 4'b1111;

  typedef enum logic [1:0] {
    EXEC_IDLE = 2'd0,
    EXEC_RUN  = 2'd1,
    EXEC_DONE = 2'd2
  } exec_state_e;

  function automatic logic [LANE_W-1:0] sat16(input logic signed [31:0] v);
    if (v > 32'sd32767) return 16'h7FFF;
    if (v < -32'sd32768) return 16'h8000;
    return v[15:0];
  endfunction

  function automatic logic is_vec_op(input logic [3:0] ft);
    return (ft == FT_VADD) || (ft == FT_VDOT) || (ft == FT_SMUL);
  endfunction

endpackage

// File: rtl/vec_lane_alu.sv
// One 16-bit lane: add and signed multiply (low 16 bits), both combinational.
// SAT_ARITH_EN clamps both results to the signed 16-bit range instead of wrapping.
module vec_lane_alu
  import cvp14_pkg::*;
(
  input  logic [LANE_W-1:0] a_i,
  input  logic [LANE_W-1:0] b_i,
  output logic [LANE_W-1:0] sum_o,
  output logic [LANE_W-1:0] prod_o
);

`ifdef SAT_ARITH_EN
  logic signed [31:0] sum_full;
  logic signed [31:0] prod_full;

  assign sum_full  = 32'($signed(a_i)) + 32'($signed(b_i));
  assign prod_full = 32'($signed(a_i)) * 32'($signed(b_i));
  assign sum_o     = sat16(sum_full);
  assign prod_o    = sat16(prod_full);
`else
  // Low 16 bits of a signed product equal those of the unsigned product.
  assign sum_o  = a_i + b_i;
  assign prod_o = a_i * b_i;
`endif

endmodule

// File: rtl/vector_exec_unit.sv
// Execute stage: vector ops walk LANES_PER_CYCLE lanes per RUN cycle, scalar ops finish in one cycle.
// SAT_ARITH_EN selects saturating vector arithmetic (address adds always wrap).
module vector_exec_unit
  import cvp14_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       functype,
  input  logic [VEC_W-1:0] op1,
  input  logic [VEC_W-1:0] op2,
  output logic             busy,
  output logic             done,
  output logic [VEC_W-1:0] result
);

  localparam int LPC = LANES_PER_CYCLE;
  localparam int K   = LANES / LPC;
  localparam int CW  = (K > 1) ? $clog2(K) : 1;
  localparam int IW  = $clog2(VEC_W);

  exec_state_e                state_q, state_d;
  logic [3:0]                 ft_q;
  logic [VEC_W-1:0]           op1_q, op2_q;
  logic [VEC_W-1:0]           work_q, work_d;
  logic [VEC_W-1:0]           result_q, result_d;
  logic [VEC_W-1:0]           scalar_res;
  logic [CW-1:0]              chunk_q, chunk_d;
  logic [LANE_W-1:0]          acc_q, acc_d, acc_step;
  logic                       last_chunk;
  logic [LPC-1:0][IW-1:0]     lane_base;
  logic [LPC-1:0][LANE_W-1:0] lane_a, lane_b, lane_sum, lane_prod;

  assign last_chunk = (chunk_q == CW'(K - 1));
  assign busy       = (state_q == EXEC_RUN);
  assign done       = (state_q == EXEC_DONE);
  assign result     = result_q;

  for (genvar j = 0; j < LPC; j++) begin : g_lane
    assign lane_base[j] = IW'((32'(chunk_q) * LPC + j) * LANE_W);
    assign lane_a[j]    = op1_q[lane_base[j] +: LANE_W];
    // SMUL broadcasts the scalar in op2[15:0] to every lane.
    assign lane_b[j]    = (ft_q == FT_SMUL) ? op2_q[LANE_W-1:0] : op2_q[lane_base[j] +: LANE_W];

    vec_lane_alu u_alu (
      .a_i    (lane_a[j]),
      .b_i    (lane_b[j]),
      .sum_o  (lane_sum[j]),
      .prod_o (lane_prod[j])
    );
  end

`ifdef SAT_ARITH_EN
  logic signed [31:0] dot_sum;

  always_comb begin
    dot_sum = 32'($signed(acc_q));
    for (int j = 0; j < LPC; j++) dot_sum = dot_sum + 32'($signed(lane_prod[j]));
    acc_step = sat16(dot_sum);
  end
`else
  always_comb begin
    acc_step = acc_q;
    for (int j = 0; j < LPC; j++) acc_step = acc_step + lane_prod[j];
  end
`endif

  always_comb begin
    work_d = work_q;
    if (state_q == EXEC_RUN) begin
      for (int j = 0; j < LPC; j++)
        work_d[lane_base[j] +: LANE_W] = (ft_q == FT_VADD) ? lane_sum[j] : lane_prod[j];
    end
  end

  always_comb begin
    scalar_res = '0;
    case (functype)
      FT_VLD, FT_VST: scalar_res[LANE_W-1:0] = op1[LANE_W-1:0] + op2[LANE_W-1:0];
      FT_SLL:         scalar_res[LANE_W-1:0] = {op1[15:8], op2[7:0]};
      FT_SLH:         scalar_res[LANE_W-1:0] = {op2[7:0], op1[7:0]};
      default:        scalar_res = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    chunk_d  = chunk_q;
    acc_d    = acc_q;
    result_d = result_q;
    case (state_q)
      EXEC_RUN: begin
        chunk_d = chunk_q + CW'(1);
        acc_d   = acc_step;
        if (last_chunk) begin
          state_d  = EXEC_DONE;
          result_d = (ft_q == FT_VDOT) ? {{(VEC_W-LANE_W){1'b0}}, acc_step} : work_d;
        end
      end
      default: begin
        state_d = EXEC_IDLE;
        if (start) begin
          chunk_d = '0;
          acc_d   = '0;
          if (is_vec_op(functype)) begin
            state_d = EXEC_RUN;
          end else begin
            state_d  = EXEC_DONE;
            result_d = scalar_res;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= EXEC_IDLE;
      ft_q     <= '0;
      op1_q    <= '0;
      op2_q    <= '0;
      work_q   <= '0;
      result_q <= '0;
      chunk_q  <= '0;
      acc_q    <= '0;
    end else begin
      state_q  <= state_d;
      work_q   <= work_d;
      result_q <= result_d;
      chunk_q  <= chunk_d;
      acc_q    <= acc_d;
      if (start && (state_q != EXEC_RUN)) begin
        ft_q  <= functype;
        op1_q <= op1;
        op2_q <= op2;
      end
    end
  end

endmodule

// File: tb/tb_vector_exec_unit.sv
// Randomized bench for vector_exec_unit against a lane-level arithmetic reference model.
// Honours SAT_ARITH_EN so the same bench covers both builds.
module tb_vector_exec_unit;

`ifdef SAT_ARITH_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [3:0]   functype = 4'h0;
  logic [255:0] op1 = '0;
  logic [255:0] op2 = '0;
  logic         busy;
  logic         done;
  logic [255:0] result;

  int n_tests = 0;
  int n_fail  = 0;

  vector_exec_unit dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .functype (functype),
    .op1      (op1),
    .op2      (op2),
    .busy     (busy),
    .done     (done),
    .result   (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] fit(input longint v);
    if (SAT && v > 32767) return 16'h7FFF;
    if (SAT && v < -32768) return 16'h8000;
    return v[15:0];
  endfunction

  function automatic longint sfit(input longint v);
    return longint'($signed(fit(v)));
  endfunction

  function automatic longint lane(input logic [255:0] v, input int i);
    return longint'($signed(v[i*16 +: 16]));
  endfunction

  function automatic logic [255:0] model(input logic [3:0] ft, input logic [255:0] a, input logic [255:0] b);
    logic [255:0] r;
    longint acc, part;
    r = '0;
    case (ft)
      4'h0: for (int i = 0; i < 16; i++) r[i*16 +: 16] = fit(lane(a, i) + lane(b, i));
      4'h2: for (int i = 0; i < 16; i++) r[i*16 +: 16] = fit(lane(a, i) * lane(b, 0));
      4'h1: begin
        acc = 0;
        if (SAT) begin
          for (int c = 0; c < 4; c++) begin
            part = 0;
            for (int j = 0; j < 4; j++) part += sfit(lane(a, 4*c+j) * lane(b, 4*c+j));
            acc = sfit(acc + part);
          end
        end else begin
          for (int i = 0; i < 16; i++) acc += lane(a, i) * lane(b, i);
        end
        r[15:0] = acc[15:0];
      end
      4'h4, 4'h5: r[15:0] = a[15:0] + b[15:0];
      4'h6: r[15:0] = {a[15:8], b[7:0]};
      4'h7: r[15:0] = {b[7:0], a[7:0]};
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic logic [255:0] rand_vec();
    logic [255:0] v;
    for (int i = 0; i < 16; i++) begin
      case ($urandom_range(0, 7))
        0: v[i*16 +: 16] = 16'h7FFF;
        1: v[i*16 +: 16] = 16'h8000;
        2: v[i*16 +: 16] = 16'hFFFF;
        3: v[i*16 +: 16] = 16'h0001;
        default: v[i*16 +: 16] = 16'($urandom);
      endcase
    end
    return v;
  endfunction

  // Issue one op from IDLE/DONE and follow it to its done pulse.
  task automatic run_op(input string tag, input logic [3:0] ft, input logic [255:0] a, input logic [255:0] b);
    logic [255:0] exp, prev;
    int lat, nbusy, held_bad;
    bit vec;
    vec  = (ft == 4'h0) || (ft == 4'h1) || (ft == 4'h2);
    exp  = model(ft, a, b);
    prev = result;
    functype = ft; op1 = a; op2 = b; start = 1'b1;
    step();
    start = 1'b0;
    functype = 4'($urandom); op1 = rand_vec(); op2 = rand_vec();
    lat = 1; nbusy = 0; held_bad = 0;
    while (done !== 1'b1 && lat < 20) begin
      if (busy === 1'b1) nbusy++;
      if (result !== prev) held_bad++;
      step();
      lat++;
    end
    check({tag, "_latency"}, 256'(lat), vec ? 256'd5 : 256'd1);
    if (vec) begin
      check({tag, "_busy_cycles"}, 256'(nbusy), 256'd4);
      check({tag, "_held_in_run"}, 256'(held_bad), 256'd0);
    end
    check({tag, "_result"}, result, exp);
    check({tag, "_busy_at_done"}, 256'(busy), 256'd0);
    step();
    check({tag, "_done_pulse"}, 256'(done), 256'd0);
  endtask

  initial begin
    logic [255:0] a, b, exp_v;
    logic [3:0] ft_list [10];
    int lat, ndone;
    ft_list = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'hF, 4'h9};

    #12;
    check("rst_busy", 256'(busy), 256'd0);
    check("rst_done", 256'(done), 256'd0);
    check("rst_result", result, 256'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    step();

    for (int i = 0; i < 16; i++) begin a[i*16 +: 16] = 16'(i + 1); b[i*16 +: 16] = 16'h0010; end
    run_op("vadd_seq", 4'h0, a, b);
    check("vadd_seq_lane5", 256'(result[5*16 +: 16]), 256'd22);

    for (int i = 0; i < 16; i++) begin a[i*16 +: 16] = 16'h0002; b[i*16 +: 16] = 16'h0003; end
    run_op("vdot_const", 4'h1, a, b);
    check("vdot_const_exact", result, 256'h60);

    a = '0; b = '0; a[15:0] = 16'h7FFF; b[15:0] = 16'h0001;
    run_op("vadd_ovf", 4'h0, a, b);
    check("vadd_ovf_lane0", 256'(result[15:0]), SAT ? 256'h7FFF : 256'h8000);

    a = rand_vec(); b = rand_vec(); a[15:0] = 16'h1000; b[15:0] = 16'hFFFE;
    run_op("vld_wrap", 4'h4, a, b);
    check("vld_wrap_exact", result, 256'h0FFE);

    // start during RUN is ignored; start in DONE launches the next op back-to-back.
    a = rand_vec(); b = rand_vec();
    exp_v = model(4'h0, a, b);
    functype = 4'h0; op1 = a; op2 = b; start = 1'b1;
    step();
    start = 1'b0;
    step();
    functype = 4'h6; op1 = 256'hAB00; op2 = 256'h34; start = 1'b1;
    step();
    start = 1'b0;
    check("ignore_busy_c3", 256'(busy), 256'd1);
    step();
    check("ignore_busy_c4", 256'(busy), 256'd1);
    step();
    check("ignore_done", 256'(done), 256'd1);
    check("ignore_result", result, exp_v);
    functype = 4'h6; op1 = 256'hAB00; op2 = 256'h34; start = 1'b1;
    step();
    start = 1'b0;
    check("b2b_sll_done", 256'(done), 256'd1);
    check("b2b_sll_result", result, 256'hAB34);
    a = rand_vec(); b = rand_vec();
    exp_v = model(4'h2, a, b);
    functype = 4'h2; op1 = a; op2 = b; start = 1'b1;
    step();
    start = 1'b0;
    check("b2b_vec_done_falls", 256'(done), 256'd0);
    check("b2b_vec_busy", 256'(busy), 256'd1);
    lat = 1;
    while (done !== 1'b1 && lat < 20) begin step(); lat++; end
    check("b2b_vec_latency", 256'(lat), 256'd5);
    check("b2b_vec_result", result, exp_v);
    step();

    // Reset in the second RUN cycle of SMUL aborts it with no done.
    functype = 4'h2; op1 = rand_vec(); op2 = rand_vec(); start = 1'b1;
    step();
    start = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    check("abort_busy", 256'(busy), 256'd0);
    check("abort_done", 256'(done), 256'd0);
    check("abort_result", result, 256'd0);
    step();
    step();
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 10; i++) begin step(); if (done === 1'b1) ndone++; end
    check("abort_no_done", 256'(ndone), 256'd0);

    for (int n = 0; n < 60; n++) begin
      run_op("rand", ft_list[$urandom_range(0, 9)], rand_vec(), rand_vec());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
